// File: rtl/alu_arb_ctrl.sv
// Two-port arbiter/sequencer that time-shares one 8-bit ALU between two requesters.
// A three-state FSM grants, executes and reports one operation every three cycles.

module alu_arb_ctrl_alu (
    input  logic [2:0] i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_result,
    output logic       o_cout,
    output logic       o_ovf
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [8:0] w_sum;

    always_comb begin
        w_sum    = 9'd0;
        o_result = 8'h00;
        o_cout   = 1'b0;
        o_ovf    = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[7:0];
                o_cout   = w_sum[8];
                o_ovf    = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
            end
            OP_SUB: begin
                // Two's-complement subtract: carry out high means no borrow.
                w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + 9'd1;
                o_result = w_sum[7:0];
                o_cout   = w_sum[8];
                o_ovf    = (i_a[7] != i_b[7]) && (w_sum[7] != i_a[7]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_a;
            OP_SHL: begin
                o_result = {i_a[6:0], 1'b0};
                o_cout   = i_a[7];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[7:1]};
                o_cout   = i_a[0];
            end
            default: o_result = 8'h00;
        endcase
    end

endmodule

module alu_arb_ctrl #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] result,
    output logic       Cout,
    output logic       O,
    output logic       Z
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] r_state;
    logic       r_last_id;
    logic       r_id;
    logic [2:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_busy;
    logic       r_done;
    logic       r_done_id;
    logic [7:0] r_result;
    logic       r_cout;
    logic       r_ovf;
    logic       r_zero;

    logic       w_any_req;
    logic       w_win_id;
    logic [2:0] w_win_op;
    logic [7:0] w_win_a;
    logic [7:0] w_win_b;
    logic [7:0] w_alu_result;
    logic       w_alu_cout;
    logic       w_alu_ovf;

    assign w_any_req = req0 | req1;

    // On a tie, round-robin favours the port that was not served last.
    always_comb begin
        w_win_id = 1'b0;
        if (req0 && req1) begin
            w_win_id = RR_ENABLE ? ~r_last_id : 1'b0;
        end else begin
            w_win_id = req1;
        end
    end

    assign w_win_op = w_win_id ? op1 : op0;
    assign w_win_a  = w_win_id ? A1  : A0;
    assign w_win_b  = w_win_id ? B1  : B0;

    alu_arb_ctrl_alu u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_cout   (w_alu_cout),
        .o_ovf    (w_alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last_id <= 1'b1;
            r_id      <= 1'b0;
            r_op      <= 3'd0;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_result  <= 8'h00;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_any_req) begin
                        r_state   <= ST_EXEC;
                        r_id      <= w_win_id;
                        r_last_id <= w_win_id;
                        r_op      <= w_win_op;
                        r_a       <= w_win_a;
                        r_b       <= w_win_b;
                        r_gnt0    <= ~w_win_id;
                        r_gnt1    <= w_win_id;
                        r_busy    <= 1'b1;
                    end else begin
                        r_gnt0 <= 1'b0;
                        r_gnt1 <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_state   <= ST_DONE;
                    r_gnt0    <= 1'b0;
                    r_gnt1    <= 1'b0;
                    r_done    <= 1'b1;
                    r_done_id <= r_id;
                    r_result  <= w_alu_result;
                    r_cout    <= w_alu_cout;
                    r_ovf     <= w_alu_ovf;
                    r_zero    <= (w_alu_result == 8'h00);
                end
                ST_DONE: begin
                    // Result, flags and done_id stay put until the next completion.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign result  = r_result;
    assign Cout    = r_cout;
    assign O       = r_ovf;
    assign Z       = r_zero;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed and randomized checks of alu_arb_ctrl against an arithmetic reference model.
// A second instance with fixed priority shares the operand inputs.

module tb_alu_arb_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, fp_req0, fp_req1;
    logic [2:0] op0, op1;
    logic [7:0] A0, B0, A1, B1;

    logic       gnt0, gnt1, busy, done, done_id, Cout, O, Z;
    logic [7:0] result;
    logic       fp_gnt0, fp_gnt1, fp_busy, fp_done, fp_done_id, fp_cout, fp_o, fp_z;
    logic [7:0] fp_result;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_m;

    alu_arb_ctrl #(.RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .op0(op0), .op1(op1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .Cout(Cout), .O(O), .Z(Z)
    );

    alu_arb_ctrl #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req0(fp_req0), .req1(fp_req1),
        .op0(op0), .op1(op1), .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .busy(fp_busy), .done(fp_done), .done_id(fp_done_id),
        .result(fp_result), .Cout(fp_cout), .O(fp_o), .Z(fp_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU using integer arithmetic on unsigned and signed views of the operands.
    task automatic ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] res, output logic c, output logic ov);
        int ua, ub, sa, sb, r, s;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; ov = 1'b0; r = 0;
        case (op)
            3'd0: begin r = ua + ub; c = (r > 255); s = sa + sb; ov = (s > 127) || (s < -128); end
            3'd1: begin r = ua - ub + 256; c = (ua >= ub); s = sa - sb; ov = (s > 127) || (s < -128); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = 255 - ua;
            3'd6: begin r = ua * 2; c = (ua >= 128); end
            default: begin r = ua / 2; c = (ua % 2) == 1; end
        endcase
        res = 8'(r % 256);
    endtask

    // One complete transaction on the round-robin instance, starting at a negedge in IDLE.
    task automatic txn(input logic r0, input logic r1,
                       input logic [2:0] o0, input logic [7:0] a0v, input logic [7:0] b0v,
                       input logic [2:0] o1, input logic [7:0] a1v, input logic [7:0] b1v);
        logic win, ec, eo;
        logic [7:0] er;
        req0 = r0; req1 = r1;
        op0 = o0; A0 = a0v; B0 = b0v;
        op1 = o1; A1 = a1v; B1 = b1v;
        win = (r0 && r1) ? !last_m : r1;
        last_m = win;
        if (win) ref_alu(o1, a1v, b1v, er, ec, eo);
        else     ref_alu(o0, a0v, b0v, er, ec, eo);
        @(posedge clk); @(negedge clk);
        chk("gnt0", gnt0, !win);
        chk("gnt1", gnt1, win);
        chk("busy_exec", busy, 1);
        chk("done_at_gnt", done, 0);
        if (win) req1 = 1'b0; else req0 = 1'b0;
        op0 = 3'($urandom); A0 = 8'($urandom); B0 = 8'($urandom);
        op1 = 3'($urandom); A1 = 8'($urandom); B1 = 8'($urandom);
        @(posedge clk); @(negedge clk);
        chk("done", done, 1);
        chk("done_id", done_id, win);
        chk("result", result, er);
        chk("cout", Cout, ec);
        chk("ovf", O, eo);
        chk("zero", Z, er == 8'h00);
        chk("gnt_with_done", {gnt0, gnt1}, 0);
        $display("txn port=%0d op=%0d result=%02h C=%0d O=%0d Z=%0d", win, win ? o1 : o0, result, Cout, O, Z);
        @(posedge clk); @(negedge clk);
        chk("done_drop", done, 0);
        chk("busy_idle", busy, 0);
        chk("result_hold", result, er);
    endtask

    initial begin
        logic win_cur;
        logic [7:0] er;
        logic ec, eo;
        int k;

        rst_n = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        op0 = 3'd0; A0 = 8'h01; B0 = 8'h01;
        op1 = 3'd0; A1 = 8'h00; B1 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done, done_id}, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {Cout, O, Z}, 0);
        chk("rst_fp", {fp_gnt0, fp_gnt1, fp_busy, fp_done}, 0);

        rst_n = 1'b1;
        last_m = 1'b1;
        txn(1, 0, 3'd0, 8'h01, 8'h01, 3'd0, 8'h00, 8'h00);

        txn(1, 0, 3'd0, 8'h7F, 8'h01, 3'd0, 8'h00, 8'h00);
        txn(1, 0, 3'd0, 8'hFF, 8'h01, 3'd0, 8'h00, 8'h00);
        txn(0, 1, 3'd0, 8'h00, 8'h00, 3'd1, 8'h05, 8'h07);
        txn(0, 1, 3'd0, 8'h00, 8'h00, 3'd6, 8'h81, 8'h00);
        txn(0, 1, 3'd0, 8'h00, 8'h00, 3'd7, 8'h81, 8'h00);
        txn(1, 0, 3'd4, 8'hAA, 8'hFF, 3'd0, 8'h00, 8'h00);
        txn(0, 1, 3'd0, 8'h00, 8'h00, 3'd5, 8'hAA, 8'h13);
        txn(1, 0, 3'd2, 8'hAA, 8'hFF, 3'd0, 8'h00, 8'h00);
        txn(0, 1, 3'd0, 8'h00, 8'h00, 3'd3, 8'h0F, 8'hF0);
        txn(1, 0, 3'd1, 8'h80, 8'h01, 3'd0, 8'h00, 8'h00);

        // Both ports held high: alternating grants 3 cycles apart; fixed priority always port 0.
        req0 = 1'b1; req1 = 1'b1; fp_req0 = 1'b1; fp_req1 = 1'b1;
        op0 = 3'd0; A0 = 8'h03; B0 = 8'h04;
        op1 = 3'd4; A1 = 8'h0F; B1 = 8'h3C;
        win_cur = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (i % 3 == 0) begin
                win_cur = !last_m;
                last_m = win_cur;
            end
            chk("rr_gnt0", gnt0, (i % 3 == 0) && !win_cur);
            chk("rr_gnt1", gnt1, (i % 3 == 0) && win_cur);
            chk("fp_gnt0", fp_gnt0, i % 3 == 0);
            chk("fp_gnt1", fp_gnt1, 0);
            chk("fp_busy", fp_busy, i % 3 != 2);
            if (i % 3 == 1) begin
                if (win_cur) ref_alu(3'd4, 8'h0F, 8'h3C, er, ec, eo);
                else         ref_alu(3'd0, 8'h03, 8'h04, er, ec, eo);
                chk("rr_done_id", {done, done_id}, {1'b1, win_cur});
                chk("rr_result", result, er);
                chk("fp_done", {fp_done, fp_done_id}, 2'b10);
                chk("fp_result", fp_result, 8'h07);
                chk("fp_flags", {fp_cout, fp_o, fp_z}, 0);
                $display("hold step=%0d rr_port=%0d rr_result=%02h fp_result=%02h", i, done_id, result, fp_result);
            end
        end
        req0 = 1'b0; req1 = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;

        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(1, 3);
            txn(k[0], k[1], 3'($urandom), 8'($urandom), 8'($urandom),
                3'($urandom), 8'($urandom), 8'($urandom));
        end

        // Reset on the EXEC edge aborts the operation.
        txn(1, 0, 3'd0, 8'h11, 8'h22, 3'd0, 8'h00, 8'h00);
        req0 = 1'b1; op0 = 3'd0; A0 = 8'h05; B0 = 8'h05;
        @(posedge clk); @(negedge clk);
        chk("abort_gnt0", gnt0, 1);
        rst_n = 1'b0; req0 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_busy", {busy, gnt0, gnt1, done_id, Cout, O, Z}, 0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("abort_no_done", {done, busy}, 0);
        last_m = 1'b1;
        txn(1, 1, 3'd1, 8'h10, 8'h20, 3'd0, 8'h01, 8'h02);
        req0 = 1'b0; req1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb_ctrl.md
# alu_arb_ctrl

Two-port arbiter and sequencer that shares one 8-bit ALU datapath (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR) between two requesters. It sits between the requesters and the ALU function units and has one FSM. The FSM does the following:
- grants one request at a time
- latches the winner's opcode and operands
- registers the result with carry, overflow and zero flags
- reports completion with a one-cycle pulse tagged with the requester ID

## Interface
- RR_ENABLE, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins every tie.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- req0, req1  input  1  request from port 0 / port 1. Held high with operands stable until the matching gnt is seen.
- op0, op1  input  3  opcode for port 0 / port 1.
- A0, B0, A1, B1  input  8  operands for port 0 / port 1.
- gnt0, gnt1  output  1  one-cycle grant pulse; operands were captured on the edge that raised it.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle result-valid pulse.
- done_id  output  1  requester served by the current done pulse.
- result  output  8  ALU result; holds its value until the next done.
- Cout  output  1  carry/shift-out flag; valid with result.
- O  output  1  signed-overflow flag; valid with result.
- Z  output  1  high when result == 8'h00.

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE -> EXEC when req0|req1 is high.
  - EXEC -> DONE unconditionally.
  - DONE -> IDLE unconditionally.
- Arbitration happens only in IDLE.
  - One request high: that port wins.
  - Both high with RR_ENABLE=1: the port other than last_id wins.
  - Both high with RR_ENABLE=0: port 0 wins.
- last_id updates to the winner on every grant. Its reset value is 1, so port 0 wins the first tie.
- On the IDLE->EXEC edge:
  - op, A and B of the winner are latched into internal registers.
  - The winner's gnt goes high for exactly one cycle.
- On the EXEC->DONE edge, the ALU is evaluated on the latched values. result, Cout, O, Z and done_id are registered, and done is set to 1.
- On the DONE->IDLE edge, done is cleared. result, flags and done_id keep their values.
- Opcode decode (the O column is O=0 unless stated):
  - 000 ADD: A+B. Cout = carry out of bit 7. O = (A[7]==B[7]) && (result[7]!=A[7]).
  - 001 SUB: A+~B+1. Cout = carry out of bit 7, so 1 means no borrow. O = (A[7]!=B[7]) && (result[7]!=A[7]).
  - 010 AND: A&B. Cout=0.
  - 011 OR: A|B. Cout=0.
  - 100 XOR: A^B. Cout=0.
  - 101 NOT: ~A; B is ignored. Cout=0.
  - 110 SHL: {A[6:0],1'b0}. Cout=A[7].
  - 111 SHR (logical): {1'b0,A[7:1]}. Cout=A[0].
- All arithmetic is modulo 2^8; no saturation.
- Requester protocol: drop req in the cycle gnt is seen. A req still high when the FSM next reaches IDLE is treated as a new request.
- Changes to req, op or operands outside IDLE have no effect.
- Reset values (rst_n low at a rising edge):
  - State = IDLE, last_id = 1.
  - gnt0, gnt1, done, done_id, busy, result, Cout, O, Z = 0.
  - Latched op and operands = 0.
- Reset mid-operation (EXEC or DONE): the operation is aborted, no done is issued, and all outputs take their reset values on that edge.

## Timing
- Request sampled high at edge k: gnt high during cycle k..k+1.
- At edge k+1: done and result valid during cycle k+1..k+2.
- At edge k+2: done drops; the FSM is back in IDLE.
- Latency from request to done = 2 cycles. Throughput = one operation per 3 cycles. The earliest next grant is edge k+3.
- gnt0 and gnt1 are never high together; done is never high together with either gnt.
- busy = 1 from edge k to edge k+2.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset: rst_n=0 for 2 cycles, with req0=1, op0=000, A0=8'h01, B0=8'h01 held during reset -> all outputs 0, no gnt during reset. rst_n=1 with req0 still high -> the first post-reset edge takes IDLE->EXEC, gnt0=1 for one cycle, then done=1 with result=8'h02.
- ADD overflow: port 0, op=000, A=8'h7F, B=8'h01 -> gnt0 at k, done at k+1 with result=8'h80, Cout=0, O=1, Z=0, done_id=0. Separately, A=8'hFF, B=8'h01 -> result=8'h00, Cout=1, O=0, Z=1.
- SUB and shifts: port 1, op=001, A=8'h05, B=8'h07 -> result=8'hFE, Cout=0, O=0, done_id=1. op=110, A=8'h81 -> result=8'h02, Cout=1. op=111, A=8'h81 -> result=8'h40, Cout=1.
- Round-robin: req0 and req1 held high continuously with RR_ENABLE=1 -> grant order is 0,1,0,1, with gnt pulses exactly 3 cycles apart. With RR_ENABLE=0 -> every grant goes to port 0.
- Logic ops: op=100, A=8'hAA, B=8'hFF -> result=8'h55. op=101, A=8'hAA -> result=8'h55. op=010, A=8'hAA, B=8'hFF -> result=8'hAA. op=011, A=8'h0F, B=8'hF0 -> result=8'hFF. Cout=0 and O=0 for all four.
- Reset mid-operation: assert rst_n=0 at the EXEC edge -> no done pulse, result=0, state IDLE. A new request after reset is served normally, and last_id=1 so port 0 wins the next tie.
